// File: rtl/icb_ppi_arb.sv
`default_nettype none
// ============================================================================
// Module   : icb_ppi_arb
// Purpose  : Two-master round-robin arbiter that lets the core PPI master (m0)
//            and a bench/debug master (m1) share one ICB slave port. An
//            in-order FIFO of master ids sends each response back to the
//            master that issued the matching command.
// Ports    : clk, rst_n (asynchronous, active low)
//            m0_icb_* / m1_icb_*  - master-side cmd/rsp channels
//            s_icb_*              - slave-side cmd/rsp channels
//            outs_cnt             - number of outstanding commands (0..OUTS_DEPTH)
//            orphan_rsp_err       - sticky flag: response seen with nothing outstanding
// Revision : 1.0 - initial release
// ============================================================================
module icb_ppi_arb #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int OUTS_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    // master 0
    input  logic                          m0_icb_cmd_valid,
    output logic                          m0_icb_cmd_ready,
    input  logic [AW-1:0]                 m0_icb_cmd_addr,
    input  logic                          m0_icb_cmd_read,
    input  logic [DW-1:0]                 m0_icb_cmd_wdata,
    input  logic [DW/8-1:0]               m0_icb_cmd_wmask,
    input  logic [1:0]                    m0_icb_cmd_size,
    output logic                          m0_icb_rsp_valid,
    input  logic                          m0_icb_rsp_ready,
    output logic                          m0_icb_rsp_err,
    output logic [DW-1:0]                 m0_icb_rsp_rdata,
    // master 1
    input  logic                          m1_icb_cmd_valid,
    output logic                          m1_icb_cmd_ready,
    input  logic [AW-1:0]                 m1_icb_cmd_addr,
    input  logic                          m1_icb_cmd_read,
    input  logic [DW-1:0]                 m1_icb_cmd_wdata,
    input  logic [DW/8-1:0]               m1_icb_cmd_wmask,
    input  logic [1:0]                    m1_icb_cmd_size,
    output logic                          m1_icb_rsp_valid,
    input  logic                          m1_icb_rsp_ready,
    output logic                          m1_icb_rsp_err,
    output logic [DW-1:0]                 m1_icb_rsp_rdata,
    // slave
    output logic                          s_icb_cmd_valid,
    input  logic                          s_icb_cmd_ready,
    output logic [AW-1:0]                 s_icb_cmd_addr,
    output logic                          s_icb_cmd_read,
    output logic [DW-1:0]                 s_icb_cmd_wdata,
    output logic [DW/8-1:0]               s_icb_cmd_wmask,
    output logic [1:0]                    s_icb_cmd_size,
    input  logic                          s_icb_rsp_valid,
    output logic                          s_icb_rsp_ready,
    input  logic                          s_icb_rsp_err,
    input  logic [DW-1:0]                 s_icb_rsp_rdata,
    // status
    output logic [$clog2(OUTS_DEPTH):0]   outs_cnt,
    output logic                          orphan_rsp_err
);

    localparam int PW = $clog2(OUTS_DEPTH);
    localparam int CW = PW + 1;

    logic                  r_rr;         // tie-break pointer: 0 -> m0 wins
    logic                  r_hold_vld;
    logic                  r_hold_id;
    logic [OUTS_DEPTH-1:0] r_ids;        // issuing master id per outstanding cmd
    logic [PW-1:0]         r_wptr;
    logic [PW-1:0]         r_rptr;
    logic [CW-1:0]         r_cnt;
    logic                  r_orphan;

    logic w_gnt;
    logic w_gnt_valid;
    logic w_full;
    logic w_empty;
    logic w_head;
    logic w_push;
    logic w_pop;

    // A held grant wins over the round-robin pointer so the slave sees a
    // stable command while it back-pressures.
    always_comb begin
        w_gnt = 1'b0;
        if (r_hold_vld) begin
            w_gnt = r_hold_id;
        end else if (m0_icb_cmd_valid && m1_icb_cmd_valid) begin
            w_gnt = r_rr;
        end else if (m1_icb_cmd_valid) begin
            w_gnt = 1'b1;
        end
    end

    assign w_gnt_valid = w_gnt ? m1_icb_cmd_valid : m0_icb_cmd_valid;
    // Full is taken from the registered count only, so a same-cycle pop
    // never opens a path from the response side to the command side.
    assign w_full      = (r_cnt == CW'(OUTS_DEPTH));
    assign w_empty     = (r_cnt == '0);
    assign w_head      = r_ids[r_rptr];

    // Handshake outputs are gated by rst_n so they are low throughout reset.
    assign s_icb_cmd_valid  = rst_n & w_gnt_valid & ~w_full;
    assign m0_icb_cmd_ready = rst_n & ~w_gnt & s_icb_cmd_ready & ~w_full;
    assign m1_icb_cmd_ready = rst_n &  w_gnt & s_icb_cmd_ready & ~w_full;

    assign s_icb_cmd_addr  = w_gnt ? m1_icb_cmd_addr  : m0_icb_cmd_addr;
    assign s_icb_cmd_read  = w_gnt ? m1_icb_cmd_read  : m0_icb_cmd_read;
    assign s_icb_cmd_wdata = w_gnt ? m1_icb_cmd_wdata : m0_icb_cmd_wdata;
    assign s_icb_cmd_wmask = w_gnt ? m1_icb_cmd_wmask : m0_icb_cmd_wmask;
    assign s_icb_cmd_size  = w_gnt ? m1_icb_cmd_size  : m0_icb_cmd_size;

    assign m0_icb_rsp_valid = rst_n & s_icb_rsp_valid & ~w_empty & ~w_head;
    assign m1_icb_rsp_valid = rst_n & s_icb_rsp_valid & ~w_empty &  w_head;
    // With nothing outstanding the response is swallowed (orphan).
    assign s_icb_rsp_ready  = rst_n & (w_empty | (w_head ? m1_icb_rsp_ready : m0_icb_rsp_ready));

    assign m0_icb_rsp_err   = s_icb_rsp_err;
    assign m1_icb_rsp_err   = s_icb_rsp_err;
    assign m0_icb_rsp_rdata = s_icb_rsp_rdata;
    assign m1_icb_rsp_rdata = s_icb_rsp_rdata;

    assign w_push = s_icb_cmd_valid & s_icb_cmd_ready;
    assign w_pop  = s_icb_rsp_valid & s_icb_rsp_ready & ~w_empty;

    assign outs_cnt       = r_cnt;
    assign orphan_rsp_err = r_orphan;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr       <= 1'b0;
            r_hold_vld <= 1'b0;
            r_hold_id  <= 1'b0;
            r_ids      <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_cnt      <= '0;
            r_orphan   <= 1'b0;
        end else begin
            if (w_push) begin
                r_rr          <= ~w_gnt;
                r_ids[r_wptr] <= w_gnt;
                r_wptr        <= r_wptr + PW'(1);
            end
            // Keep the grant while the chosen master waits; drop it once the
            // handshake completes or the master (illegally) withdraws valid.
            r_hold_vld <= w_gnt_valid & ~w_push;
            r_hold_id  <= w_gnt;
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
            if (s_icb_rsp_valid && w_empty) begin
                r_orphan <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_icb_ppi_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_icb_ppi_arb
// Purpose  : Directed self-checking bench for icb_ppi_arb. Inputs change on
//            the falling edge; outputs are checked 1 time unit later.
// Revision : 1.0 - initial release
// ============================================================================
module tb_icb_ppi_arb;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int OUTS_DEPTH = 4;
    localparam logic [31:0] c_A0 = 32'h1004_0000;
    localparam logic [31:0] c_A1 = 32'h1004_1000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic m0v, m0r, m0_rd, m0rv, m0rr, m0re;
    logic m1v, m1r, m1_rd, m1rv, m1rr, m1re;
    logic [AW-1:0] m0a, m1a, sa;
    logic [DW-1:0] m0wd, m1wd, m0rd, m1rd, swd, srd;
    logic [DW/8-1:0] m0wm, m1wm, swm;
    logic [1:0] m0sz, m1sz, ssz;
    logic sv, sr, s_rd, srv, srr, sre;
    logic [$clog2(OUTS_DEPTH):0] cnt;
    logic orphan;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    icb_ppi_arb #(.AW(AW), .DW(DW), .OUTS_DEPTH(OUTS_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_icb_cmd_valid(m0v), .m0_icb_cmd_ready(m0r), .m0_icb_cmd_addr(m0a),
        .m0_icb_cmd_read(m0_rd), .m0_icb_cmd_wdata(m0wd), .m0_icb_cmd_wmask(m0wm),
        .m0_icb_cmd_size(m0sz), .m0_icb_rsp_valid(m0rv), .m0_icb_rsp_ready(m0rr),
        .m0_icb_rsp_err(m0re), .m0_icb_rsp_rdata(m0rd),
        .m1_icb_cmd_valid(m1v), .m1_icb_cmd_ready(m1r), .m1_icb_cmd_addr(m1a),
        .m1_icb_cmd_read(m1_rd), .m1_icb_cmd_wdata(m1wd), .m1_icb_cmd_wmask(m1wm),
        .m1_icb_cmd_size(m1sz), .m1_icb_rsp_valid(m1rv), .m1_icb_rsp_ready(m1rr),
        .m1_icb_rsp_err(m1re), .m1_icb_rsp_rdata(m1rd),
        .s_icb_cmd_valid(sv), .s_icb_cmd_ready(sr), .s_icb_cmd_addr(sa),
        .s_icb_cmd_read(s_rd), .s_icb_cmd_wdata(swd), .s_icb_cmd_wmask(swm),
        .s_icb_cmd_size(ssz), .s_icb_rsp_valid(srv), .s_icb_rsp_ready(srr),
        .s_icb_rsp_err(sre), .s_icb_rsp_rdata(srd),
        .outs_cnt(cnt), .orphan_rsp_err(orphan)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge (one full clock later).
    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        m0v = 1'b1; m0a = c_A0; m0_rd = 1'b0; m0wd = 32'h41; m0wm = 4'hF; m0sz = 2'd2;
        m1v = 1'b0; m1a = c_A1; m1_rd = 1'b1; m1wd = 32'h0;  m1wm = 4'h0; m1sz = 2'd2;
        m0rr = 1'b1; m1rr = 1'b1;
        sr = 1'b1; srv = 1'b1; sre = 1'b0; srd = 32'h0;

        // ---------------- reset state ----------------
        tick(); tick(); #1;
        chk("rst_s_cmd_valid", 64'(sv), 64'd0);
        chk("rst_m0_cmd_ready", 64'(m0r), 64'd0);
        chk("rst_s_rsp_ready", 64'(srr), 64'd0);
        chk("rst_m0_rsp_valid", 64'(m0rv), 64'd0);
        chk("rst_outs_cnt", 64'(cnt), 64'd0);
        chk("rst_orphan", 64'(orphan), 64'd0);
        chk("rst_addr_from_m0", 64'(sa), 64'(c_A0));

        tick();
        rst_n = 1'b1; m0v = 1'b0; srv = 1'b0;

        // ---------------- single master write ----------------
        tick();
        m0v = 1'b1; #1;
        chk("single_s_cmd_valid", 64'(sv), 64'd1);
        chk("single_addr", 64'(sa), 64'(c_A0));
        chk("single_wdata", 64'(swd), 64'h41);
        chk("single_m0_ready", 64'(m0r), 64'd1);
        chk("single_m1_ready", 64'(m1r), 64'd0);
        tick();                                  // rr -> 1, cnt 1
        m0v = 1'b0; #1;
        chk("single_cnt1", 64'(cnt), 64'd1);
        srv = 1'b1; srd = 32'hA5; sre = 1'b1; #1;
        chk("single_rsp_m0", 64'(m0rv), 64'd1);
        chk("single_rsp_m1", 64'(m1rv), 64'd0);
        chk("single_s_rsp_ready", 64'(srr), 64'd1);
        chk("single_rdata_bcast", 64'(m1rd), 64'hA5);
        chk("single_err_bcast", 64'(m0re), 64'd1);
        tick();
        srv = 1'b0; sre = 1'b0; #1;
        chk("single_cnt0", 64'(cnt), 64'd0);

        // ---------------- contention (rr=1 -> m1 first) ----------------
        m0v = 1'b1; m1v = 1'b1; #1;
        chk("cont_a_addr_m1", 64'(sa), 64'(c_A1));
        chk("cont_a_m0_ready", 64'(m0r), 64'd0);
        tick(); #1;
        chk("cont_b_addr_m0", 64'(sa), 64'(c_A0));
        chk("cont_b_m0_ready", 64'(m0r), 64'd1);
        tick(); #1;
        chk("cont_c_addr_m1", 64'(sa), 64'(c_A1));
        tick(); #1;
        chk("cont_d_addr_m0", 64'(sa), 64'(c_A0));
        tick(); #1;                              // FIFO ids: 1,0,1,0
        chk("full_cnt4", 64'(cnt), 64'd4);
        chk("full_s_cmd_valid", 64'(sv), 64'd0);
        chk("full_m0_ready", 64'(m0r), 64'd0);
        chk("full_m1_ready", 64'(m1r), 64'd0);
        // response in the same cycle must not unblock commands
        srv = 1'b1; #1;
        chk("full_rsp_m1", 64'(m1rv), 64'd1);
        chk("full_rsp_m0", 64'(m0rv), 64'd0);
        chk("full_pop_still_blocked", 64'(sv), 64'd0);
        chk("full_pop_m1_ready", 64'(m1r), 64'd0);
        tick(); #1;                              // cnt 3, hold on m1
        chk("after_full_cnt3", 64'(cnt), 64'd3);
        chk("fifth_m1_ready", 64'(m1r), 64'd1);
        chk("fifth_addr_m1", 64'(sa), 64'(c_A1));
        chk("fifth_rsp_m0", 64'(m0rv), 64'd1);
        chk("fifth_rsp_m1", 64'(m1rv), 64'd0);
        tick();                                  // push 1 + pop 0: cnt 3, rr 0
        m0v = 1'b0; m1v = 1'b0;
        // ---------------- head backpressure: head is m1 ----------------
        m1rr = 1'b0; #1;
        chk("pushpop_cnt3", 64'(cnt), 64'd3);
        chk("bp_m1_valid", 64'(m1rv), 64'd1);
        chk("bp_m0_valid", 64'(m0rv), 64'd0);
        chk("bp_s_rsp_ready", 64'(srr), 64'd0);
        tick(); #1;
        chk("bp_cnt_held", 64'(cnt), 64'd3);
        chk("bp_m0_still_blocked", 64'(m0rv), 64'd0);
        m1rr = 1'b1; #1;
        chk("bp_release_ready", 64'(srr), 64'd1);
        tick(); #1;
        chk("drain_m0", 64'(m0rv), 64'd1);
        tick(); #1;
        chk("drain_m1", 64'(m1rv), 64'd1);
        tick();
        srv = 1'b0; #1;
        chk("drain_cnt0", 64'(cnt), 64'd0);

        // ---------------- hold (make rr=1 first) ----------------
        m0v = 1'b1; sr = 1'b1;
        tick();                                  // m0 accepted, rr 1, cnt 1
        sr = 1'b0; #1;
        chk("hold1_addr", 64'(sa), 64'(c_A0));
        chk("hold1_m0_ready", 64'(m0r), 64'd0);
        tick();
        m1v = 1'b1; #1;
        chk("hold2_addr", 64'(sa), 64'(c_A0));
        chk("hold2_m1_ready", 64'(m1r), 64'd0);
        tick(); #1;
        chk("hold3_addr", 64'(sa), 64'(c_A0));
        tick();
        sr = 1'b1; #1;
        chk("hold4_m0_ready", 64'(m0r), 64'd1);
        chk("hold4_m1_ready", 64'(m1r), 64'd0);
        tick();
        m0v = 1'b0; #1;
        chk("hold5_m1_ready", 64'(m1r), 64'd1);
        chk("hold5_addr", 64'(sa), 64'(c_A1));
        tick();
        m1v = 1'b0; #1;                          // FIFO ids: 0,0,1
        chk("hold_cnt3", 64'(cnt), 64'd3);
        srv = 1'b1; #1;
        chk("hdrain0_m0", 64'(m0rv), 64'd1);
        tick(); #1;
        chk("hdrain1_m0", 64'(m0rv), 64'd1);
        tick(); #1;
        chk("hdrain2_m1", 64'(m1rv), 64'd1);
        chk("hdrain2_m0", 64'(m0rv), 64'd0);
        tick(); #1;

        // ---------------- orphan (srv still 1, FIFO empty) ----------------
        chk("orphan_cnt0", 64'(cnt), 64'd0);
        chk("orphan_s_rsp_ready", 64'(srr), 64'd1);
        chk("orphan_no_m0_valid", 64'(m0rv), 64'd0);
        chk("orphan_no_m1_valid", 64'(m1rv), 64'd0);
        tick();
        srv = 1'b0; #1;
        chk("orphan_flag", 64'(orphan), 64'd1);
        chk("orphan_cnt_stays0", 64'(cnt), 64'd0);

        // ---------------- reset with 2 outstanding ----------------
        m0v = 1'b1;
        tick(); tick();
        m0v = 1'b0; #1;
        chk("pre_rst_cnt2", 64'(cnt), 64'd2);
        chk("orphan_sticky", 64'(orphan), 64'd1);
        tick();
        rst_n = 1'b0; #1;
        chk("async_rst_cnt", 64'(cnt), 64'd0);
        chk("async_rst_orphan", 64'(orphan), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        srv = 1'b1; #1;
        chk("post_rst_rsp_m0", 64'(m0rv), 64'd0);
        tick();
        srv = 1'b0; #1;
        chk("post_rst_orphan", 64'(orphan), 64'd1);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
